tpu_a_skew_buf: RTL and testbench
=================================

Name: tpu_a_skew_buf

Overview:
- Input staging buffer that sits directly upstream of the tpumac array. It feeds the Ain edge of each systolic row.
- Holds one DIM x DIM tile of A, written one row per cycle.
- On each enable, shifts the tile out with row i delayed by i cycles, giving the diagonal wavefront the MAC grid needs.
- Also reports when the tile has fully drained.

Parameters:
- BITS_AB, 8, signed element width (matches tpumac A/B operand width).
- DIM, 8, array dimension: number of rows and elements per row; must be >= 2.
- CNT_W, $clog2(2*DIM), width of the drain counter (localparam, derived).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance all rows by one position (same enable that steps the MAC array).
- WrEn  input  1  load the row selected by Arow from Ain.
- Arow  input  $clog2(DIM)  row index for the write.
- Ain  input  BITS_AB*DIM  packed signed row; element j at bits [j*BITS_AB +: BITS_AB].
- Aout  output  BITS_AB*DIM  packed signed; element i drives systolic row i's Ain.
- drained  output  1  high when no loaded data remains in any chain.

Behaviour:
- Storage: row i is a shift chain of DIM+i registers, cells 0..DIM+i-1.
- Aout[i] = cell 0 of row i, driven straight from the register (no combinational path from inputs).
- Reset (async, rst_n=0): all cells 0, Aout=0, drain counter = 2*DIM-1 (saturated), drained=1.
- Write (WrEn=1, rising edge):
  - Row Arow gets cell (Arow+j) <= Ain element j, for j=0..DIM-1.
  - Cells 0..Arow-1 of that row keep their contents; pending data from a previous tile is not cleared.
  - Other rows are unchanged.
  - Drain counter <= 0; drained <= 0.
- Shift (en=1, WrEn=0):
  - Every row: cell k <= cell k+1, and the top cell <= 0 (zeros shift in).
  - Drain counter increments, saturating at 2*DIM-1.
  - drained = (counter == 2*DIM-1), registered.
- Simultaneous WrEn and en: the write wins. No shift occurs in any row and the counter resets to 0. The upstream controller must not overlap the two.
- Neither asserted: full hold.
- Arow >= DIM (only possible when DIM is not a power of 2): the write is ignored entirely; the counter is not reset.
- Skew:
  - After writing row i, element 0 of row i appears on Aout[i] after i shifts.
  - Element j of row i appears after i+j shifts.
  - The last element of the tile (row DIM-1, element DIM-1) appears after 2*DIM-2 shifts.
  - All outputs are 0 after 2*DIM-1 shifts, which matches the drained assertion.
- Reset mid-drain: all state clears immediately (asynchronous).
- No arithmetic: values pass bit-exact, sign preserved.

Decomposition:
- Shared package tpu_pkg holds:
  - BITS_AB and DIM defaults, so this block and the tpumac grid stay consistent.
  - A typedef for the signed element type, logic signed [BITS_AB-1:0].
- Sub-module tpu_skew_row:
  - One shift chain with parameters DEPTH and OFFSET.
  - Ports: clk, rst_n, en, wr, din row, dout.
  - The top level instantiates it DIM times with DEPTH=DIM+i and OFFSET=i, and owns the drain counter.

Test Plan:
1. Reset -> Aout=0, drained=1. Then pulse en 3 times -> Aout stays 0, drained stays 1.
2. DIM=4, BITS_AB=8. Write rows 0..3 with A[r][c]=4r+c+1, no en.
   - Immediately after the writes: Aout={r0:1, r1:0, r2:0, r3:0}, drained=0.
   - en#1 -> {2,5,0,0}. en#2 -> {3,6,9,0}. en#3 -> {4,7,10,13}.
   - en#6 -> {0,0,0,16}. en#7 -> all 0, drained=1.
3. Signed pass-through: write row 0 with {-128,-1,127,0}; shift 3 times -> Aout[0] sequence is -128,-1,127,0 (bit-exact 0x80,0xFF,0x7F,0x00).
4. WrEn and en high together on the same cycle, writing row 2 mid-drain -> no row shifts, row 2 cells 2..5 are loaded, cells 0..1 keep prior data, drain counter = 0.
5. Assert rst_n=0 asynchronously between clock edges during drain (after en#2 of scenario 2) -> Aout=0 and drained=1 without waiting for a clock edge. Subsequent en pulses produce only zeros.
6. Overwrite an undrained row: load row 1 with 1..4, shift once, reload row 1 with 11..14 -> Aout[1] shows 11,12,13,14 on the next 4 shifts, then 0 (the old data in cell 0 was consumed by the first shift).

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath defaults so the skew buffer and the MAC grid agree on
// operand width and array size.
package tpu_pkg;

    localparam int TPU_BITS_AB = 8;
    localparam int TPU_DIM     = 8;

    typedef logic signed [TPU_BITS_AB-1:0] elem_t;

endpackage : tpu_pkg

// File: rtl/tpu_skew_row.sv
// One row of the A skew buffer: a DEPTH-cell shift chain whose write lands at
// cells OFFSET..OFFSET+DIM-1, so the row's first element emerges OFFSET shifts late.
module tpu_skew_row
    import tpu_pkg::*;
#(
    parameter int BITS_AB = TPU_BITS_AB,
    parameter int DIM     = TPU_DIM,
    parameter int DEPTH   = DIM,
    parameter int OFFSET  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   wr,
    input  logic [BITS_AB*DIM-1:0] din,
    output logic [BITS_AB-1:0]     dout
);

    logic [BITS_AB-1:0] r_cell      [DEPTH];
    logic [BITS_AB-1:0] w_cell_next [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [BITS_AB-1:0] w_shift_in;

            if (gi == DEPTH - 1) begin : g_top
                assign w_shift_in = '0;
            end else begin : g_mid
                assign w_shift_in = r_cell[gi+1];
            end

            // Cells below OFFSET are outside the write window and keep any
            // older tile data still draining through them.
            if (gi >= OFFSET) begin : g_load
                assign w_cell_next[gi] = wr ? din[(gi-OFFSET)*BITS_AB +: BITS_AB] :
                                         en ? w_shift_in : r_cell[gi];
            end else begin : g_hold
                assign w_cell_next[gi] = wr ? r_cell[gi] :
                                         en ? w_shift_in : r_cell[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_cell[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_cell[k] <= w_cell_next[k];
            end
        end
    end

    assign dout = r_cell[0];

endmodule : tpu_skew_row

// File: rtl/tpu_a_skew_buf.sv
// A-operand staging buffer: holds one DIMxDIM tile and shifts it out with row i
// delayed by i cycles to form the systolic wavefront; flags when fully drained.
module tpu_a_skew_buf
    import tpu_pkg::*;
#(
    parameter int BITS_AB = TPU_BITS_AB,
    parameter int DIM     = TPU_DIM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   WrEn,
    input  logic [$clog2(DIM)-1:0] Arow,
    input  logic [BITS_AB*DIM-1:0] Ain,
    output logic [BITS_AB*DIM-1:0] Aout,
    output logic                   drained
);

    localparam int ROW_W = $clog2(DIM);
    localparam int CNT_W = $clog2(2*DIM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*DIM - 1);

    logic             w_wr_valid;
    logic             w_shift;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drained;

    // An out-of-range row index is a non-write, so en still shifts normally.
    assign w_wr_valid = WrEn && (32'(Arow) < DIM);
    assign w_shift    = en && !w_wr_valid;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_row
            logic w_row_wr;
            assign w_row_wr = w_wr_valid && (Arow == ROW_W'(gi));

            tpu_skew_row #(
                .BITS_AB (BITS_AB),
                .DIM     (DIM),
                .DEPTH   (DIM + gi),
                .OFFSET  (gi)
            ) u_row (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_shift),
                .wr    (w_row_wr),
                .din   (Ain),
                .dout  (Aout[gi*BITS_AB +: BITS_AB])
            );
        end
    endgenerate

    // 2*DIM-1 shifts after the last write every chain holds only zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= CNT_MAX;
            r_drained <= 1'b1;
        end else if (w_wr_valid) begin
            r_cnt     <= '0;
            r_drained <= 1'b0;
        end else if (w_shift) begin
            r_cnt     <= w_cnt_inc;
            r_drained <= (w_cnt_inc == CNT_MAX);
        end
    end

    assign drained = r_drained;

endmodule : tpu_a_skew_buf

// File: tb/tb_tpu_a_skew_buf.sv
// Scoreboard bench for tpu_a_skew_buf at DIM=4, BITS_AB=8.
module tb_tpu_a_skew_buf;
    import tpu_pkg::*;

    localparam int BITS = 8;
    localparam int D    = 4;
    localparam int MAXC = 2*D - 1;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              WrEn;
    logic [1:0]        Arow;
    logic [BITS*D-1:0] Ain;
    logic [BITS*D-1:0] Aout;
    logic              drained;

    int n_vec;
    int n_err;

    // Behavioural reference: row r holds D+r cells, plus a drain counter.
    int m_cell [D][2*D];
    int m_cnt;
    logic [BITS*D:0] sb_q [$];

    tpu_a_skew_buf #(.BITS_AB(BITS), .DIM(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .WrEn    (WrEn),
        .Arow    (Arow),
        .Ain     (Ain),
        .Aout    (Aout),
        .drained (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BITS*D:0] model_out();
        logic [BITS*D:0] v;
        v = '0;
        for (int i = 0; i < D; i++) v[i*BITS +: BITS] = m_cell[i][0][BITS-1:0];
        v[BITS*D] = (m_cnt == MAXC);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < D; r++)
            for (int k = 0; k < 2*D; k++) m_cell[r][k] = 0;
        m_cnt = MAXC;
    endtask

    task automatic model_step(input logic wr, input int row, input logic [BITS*D-1:0] ain, input logic sh);
        if (wr && row < D) begin
            for (int j = 0; j < D; j++) m_cell[row][row+j] = int'(ain[j*BITS +: BITS]);
            m_cnt = 0;
        end else if (sh) begin
            for (int r = 0; r < D; r++) begin
                for (int k = 0; k < D + r - 1; k++) m_cell[r][k] = m_cell[r][k+1];
                m_cell[r][D+r-1] = 0;
            end
            if (m_cnt < MAXC) m_cnt++;
        end
    endtask

    // One clock: drive, push expectation, clock, pop and compare.
    task automatic cyc(input string tag, input logic wr, input int row, input logic [BITS*D-1:0] ain, input logic sh);
        logic [BITS*D:0] exp;
        @(negedge clk);
        WrEn = wr; Arow = row[1:0]; Ain = ain; en = sh;
        model_step(wr, row, ain, sh);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        WrEn = 1'b0; en = 1'b0;
        exp = sb_q.pop_front();
        $display("%s wr=%0b row=%0d ain=%h en=%0b -> Aout=%h drained=%0b", tag, wr, row, ain, sh, Aout, drained);
        chk({tag, "_aout"}, 64'(Aout), 64'(exp[BITS*D-1:0]));
        chk({tag, "_drained"}, 64'(drained), 64'(exp[BITS*D]));
    endtask

    function automatic logic [BITS*D-1:0] tile_row(input int r);
        logic [BITS*D-1:0] v;
        for (int c = 0; c < D; c++) v[c*BITS +: BITS] = 8'(4*r + c + 1);
        return v;
    endfunction

    task automatic load_tile();
        for (int r = 0; r < D; r++) cyc("load", 1'b1, r, tile_row(r), 1'b0);
    endtask

    logic [31:0] t2_exp [8];
    logic [7:0]  t3_exp [4];
    logic [7:0]  t4_exp [6];
    elem_t       e_got;

    initial begin
        n_vec = 0; n_err = 0;
        en = 0; WrEn = 0; Arow = '0; Ain = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aout", 64'(Aout), 64'h0);
        chk("rst_drained", 64'(drained), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: shifting an empty buffer stays empty and drained
        for (int i = 0; i < 3; i++) cyc("t1_en", 1'b0, 0, '0, 1'b1);

        // 2: full tile drain
        t2_exp = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
                   32'h0E0B0800, 32'h0F0C0000, 32'h10000000, 32'h00000000};
        load_tile();
        chk("t2_load", 64'(Aout), 64'(t2_exp[0]));
        chk("t2_load_drained", 64'(drained), 64'h0);
        for (int s = 1; s <= 7; s++) begin
            cyc("t2_en", 1'b0, 0, '0, 1'b1);
            chk($sformatf("t2_en%0d", s), 64'(Aout), 64'(t2_exp[s]));
        end
        chk("t2_drained", 64'(drained), 64'h1);

        // 3: signed pass-through on row 0
        t3_exp = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        cyc("t3_wr", 1'b1, 0, {8'h00, 8'h7F, 8'hFF, 8'h80}, 1'b0);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) cyc("t3_en", 1'b0, 0, '0, 1'b1);
            e_got = elem_t'(Aout[7:0]);
            chk($sformatf("t3_a0_%0d", s), 64'(Aout[7:0]), 64'(t3_exp[s]));
            chk($sformatf("t3_sign_%0d", s), 64'(e_got < 0), 64'(t3_exp[s][7]));
        end
        for (int s = 0; s < 4; s++) cyc("t3_flush", 1'b0, 0, '0, 1'b1);

        // 6: overwrite an undrained row
        cyc("t6_wr1", 1'b1, 1, 32'h04030201, 1'b0);
        cyc("t6_en", 1'b0, 0, '0, 1'b1);
        cyc("t6_wr2", 1'b1, 1, 32'h0E0D0C0B, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cyc("t6_en", 1'b0, 0, '0, 1'b1);
            chk($sformatf("t6_a1_%0d", s), 64'(Aout[15:8]), (s < 4) ? 64'(11 + s) : 64'h0);
        end
        for (int s = 0; s < 3; s++) cyc("t6_flush", 1'b0, 0, '0, 1'b1);

        // 4: WrEn and en together mid-drain -> write wins, nothing shifts
        load_tile();
        cyc("t4_en", 1'b0, 0, '0, 1'b1);
        cyc("t4_en", 1'b0, 0, '0, 1'b1);
        cyc("t4_both", 1'b1, 2, 32'h24232221, 1'b1);
        chk("t4_noshift", 64'(Aout), 64'h00090603);
        t4_exp = '{8'h0A, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00};
        for (int s = 0; s < 7; s++) begin
            cyc("t4_en", 1'b0, 0, '0, 1'b1);
            if (s < 6) chk($sformatf("t4_a2_%0d", s), 64'(Aout[23:16]), 64'(t4_exp[s]));
            chk($sformatf("t4_drn_%0d", s), 64'(drained), (s == 6) ? 64'h1 : 64'h0);
        end

        // 5: asynchronous reset mid-drain
        load_tile();
        cyc("t5_en", 1'b0, 0, '0, 1'b1);
        cyc("t5_en", 1'b0, 0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_aout", 64'(Aout), 64'h0);
        chk("t5_async_drained", 64'(drained), 64'h1);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) cyc("t5_en", 1'b0, 0, '0, 1'b1);

        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_tpu_a_skew_buf
